// File: rtl/display_placar.sv
// display_placar: shot-clock / score output stage.
// Drives a 4-digit multiplexed common-anode 7-segment display and stretches
// the buzzer level into a fixed-length audible pulse.
// Ports:
//   clock       system clock (rising edge)
//   reset       asynchronous, active-high reset
//   cronometro  shot-clock seconds 0..31  -> digits 1:0
//   pontos      team score 0..127         -> digits 3:2 (>=100 shows dashes)
//   buzzer_in   buzzer level, synchronous to clock
//   apagar      1 = all anodes off while scanning continues
//   segmentos   segments g..a, active-low, registered
//   anodos      digit enables, active-low, bit0 = shot-clock units, registered
//   buzzer_out  stretched buzzer drive, registered
module display_placar #(
  parameter int REFRESH_DIV = 50000,    // cycles each digit stays lit (>= 2)
  parameter int BUZZER_HOLD = 25000000  // buzzer_out length in cycles (>= 1)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] cronometro,
  input  logic [6:0] pontos,
  input  logic       buzzer_in,
  input  logic       apagar,
  output logic [6:0] segmentos,
  output logic [3:0] anodos,
  output logic       buzzer_out
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BUZZER_HOLD + 1);

  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] HOLD_VAL = BW'(BUZZER_HOLD);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low g..a pattern for one decimal digit; codes 10..15 never occur
  // and are shown blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [RW-1:0] ref_q,       ref_d;
  logic [1:0]    idx_q,       idx_d;
  logic [4:0]    snap_cron_q, snap_cron_d;
  logic [6:0]    snap_pts_q,  snap_pts_d;
  logic          first_q,     first_d;     // set in reset: capture on first live cycle
  logic [6:0]    seg_q,       seg_d;
  logic [3:0]    an_q,        an_d;
  logic [BW-1:0] buz_cnt_q,   buz_cnt_d;
  logic          buz_prev_q,  buz_prev_d;
  logic          buz_out_q,   buz_out_d;

  // ---------------------------------------------------------------------
  // Refresh scan and snapshot
  // ---------------------------------------------------------------------
  logic wrap;
  logic capture;

  always_comb begin
    wrap    = (ref_q == REF_LAST);
    ref_d   = wrap ? '0 : ref_q + 1'b1;
    idx_d   = wrap ? idx_q + 2'd1 : idx_q;
    first_d = 1'b0;
    // Sample only at the start of a scan so all four digits come from the
    // same values and a scan never shows a torn number.
    capture     = first_q | (wrap & (idx_q == 2'd3));
    snap_cron_d = capture ? cronometro : snap_cron_q;
    snap_pts_d  = capture ? pontos     : snap_pts_q;
  end

  // ---------------------------------------------------------------------
  // Binary-to-BCD and digit selection
  // ---------------------------------------------------------------------
  logic [3:0] sc_tens, sc_units, pt_tens, pt_units;
  logic       pts_over;
  logic [6:0] seg_sel;

  always_comb begin
    // Constant divisors on 5/7-bit operands reduce to small lookup logic.
    sc_tens  = 4'(snap_cron_q / 5'd10);
    sc_units = 4'(snap_cron_q % 5'd10);
    pt_tens  = 4'(snap_pts_q / 7'd10);
    pt_units = 4'(snap_pts_q % 7'd10);
    pts_over = (snap_pts_q >= 7'd100);

    seg_sel = SEG_BLANK;
    case (idx_q)
      2'd0: seg_sel = seg7(sc_units);
      2'd1: seg_sel = (snap_cron_q < 5'd10) ? SEG_BLANK : seg7(sc_tens);
      2'd2: seg_sel = pts_over ? SEG_DASH : seg7(pt_units);
      2'd3: begin
        if (pts_over)                seg_sel = SEG_DASH;
        else if (snap_pts_q < 7'd10) seg_sel = SEG_BLANK;
        else                         seg_sel = seg7(pt_tens);
      end
      default: seg_sel = SEG_BLANK;
    endcase

    // Segments keep following the scan while blanked so that releasing
    // apagar shows the right digit immediately.
    seg_d = seg_sel;
    an_d  = apagar ? 4'b1111 : ~(4'b0001 << idx_q);
  end

  // ---------------------------------------------------------------------
  // Buzzer stretcher
  // ---------------------------------------------------------------------
  logic buz_rise;

  always_comb begin
    buz_rise   = buzzer_in & ~buz_prev_q;
    buz_prev_d = buzzer_in;
    // A new rising edge reloads even mid-pulse, extending it; a held level
    // produces only the one edge.
    if (buz_rise)                buz_cnt_d = HOLD_VAL;
    else if (buz_cnt_q != '0)    buz_cnt_d = buz_cnt_q - 1'b1;
    else                         buz_cnt_d = buz_cnt_q;
    buz_out_d = (buz_cnt_d != '0);
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ref_q       <= '0;
      idx_q       <= 2'd0;
      snap_cron_q <= 5'd0;
      snap_pts_q  <= 7'd0;
      first_q     <= 1'b1;
      seg_q       <= SEG_BLANK;
      an_q        <= 4'b1111;
      buz_cnt_q   <= '0;
      buz_prev_q  <= 1'b0;
      buz_out_q   <= 1'b0;
    end else begin
      ref_q       <= ref_d;
      idx_q       <= idx_d;
      snap_cron_q <= snap_cron_d;
      snap_pts_q  <= snap_pts_d;
      first_q     <= first_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      buz_cnt_q   <= buz_cnt_d;
      buz_prev_q  <= buz_prev_d;
      buz_out_q   <= buz_out_d;
    end
  end

  assign segmentos  = seg_q;
  assign anodos     = an_q;
  assign buzzer_out = buz_out_q;

endmodule

// File: tb/tb_display_placar.sv
// tb_display_placar: directed bench for display_placar.
// Table of {shot clock, score, expected digit patterns} applied scan by scan,
// plus hand-written sequences for buzzer, apagar, tearing and reset corners.
module tb_display_placar;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b0111111;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] cronometro = 5'd0;
  logic [6:0] pontos = 7'd0;
  logic       buzzer_in = 1'b0;
  logic       apagar = 1'b0;
  logic [6:0] segmentos;
  logic [3:0] anodos;
  logic       buzzer_out;

  display_placar #(.REFRESH_DIV(4), .BUZZER_HOLD(10)) dut (
    .clock      (clock),
    .reset      (reset),
    .cronometro (cronometro),
    .pontos     (pontos),
    .buzzer_in  (buzzer_in),
    .apagar     (apagar),
    .segmentos  (segmentos),
    .anodos     (anodos),
    .buzzer_out (buzzer_out)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc  = 0;   // edges since reset release; a scan is 16 edges

  typedef struct packed {
    logic [4:0]      cron;
    logic [6:0]      pts;
    logic [3:0][6:0] seg;   // [d] = expected pattern of digit d
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clock);
    #1;
    ncyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b want %0b", nm, got, exp);
    end
  endtask

  // Step until the edge that captures the inputs for the next scan.
  task automatic sync_capture();
    do step(); while (ncyc % 16 != 0);
  endtask

  // Check one full scan; call when aligned on a capture edge.
  task automatic check_scan(input string nm, input logic [3:0][6:0] exp);
    for (int i = 0; i < 16; i++) begin
      int d;
      logic [3:0] ea;
      step();
      d  = i / 4;
      ea = ~(4'b0001 << d);
      chk($sformatf("%s d%0d an", nm, d), {28'd0, anodos}, {28'd0, ea});
      chk($sformatf("%s d%0d seg", nm, d), {25'd0, segmentos}, {25'd0, exp[d]});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{cron: 5'd24, pts: 7'd7,   seg: {SB, S7, S2, S4}};
    vecs[1] = '{cron: 5'd5,  pts: 7'd100, seg: {SD, SD, SB, S5}};
    vecs[2] = '{cron: 5'd31, pts: 7'd99,  seg: {S9, S9, S3, S1}};
    vecs[3] = '{cron: 5'd10, pts: 7'd10,  seg: {S1, S0, S1, S0}};
    vecs[4] = '{cron: 5'd0,  pts: 7'd0,   seg: {SB, S0, SB, S0}};
    vecs[5] = '{cron: 5'd18, pts: 7'd127, seg: {SD, SD, S1, S8}};
    vecs[6] = '{cron: 5'd9,  pts: 7'd56,  seg: {S5, S6, SB, S9}};

    // Reset held
    step(); step();
    chk("reset an",  {28'd0, anodos},     32'b1111);
    chk("reset seg", {25'd0, segmentos},  32'b1111111);
    chk("reset buz", {31'd0, buzzer_out}, 32'd0);

    // Release; the first digit shown is index 0, snapshot taken on edge 1
    cronometro = 5'd24;
    pontos     = 7'd7;
    reset      = 1'b0;
    ncyc       = 0;
    step();
    chk("first an", {28'd0, anodos}, 32'b1110);
    step();
    chk("first seg", {25'd0, segmentos}, {25'd0, S4});
    sync_capture();

    // Table-driven scans
    for (int v = 0; v < 7; v++) begin
      cronometro = vecs[v].cron;
      pontos     = vecs[v].pts;
      sync_capture();
      check_scan($sformatf("vec%0d", v), vecs[v].seg);
    end

    // Tearing: change mid-scan, the current scan keeps the old sample
    cronometro = 5'd24;
    pontos     = 7'd7;
    sync_capture();
    step();
    cronometro = 5'd23;
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("tear e%0d seg", i), {25'd0, segmentos}, {25'd0, (i < 4) ? S4 : S2});
    end
    for (int i = 8; i < 16; i++) step();
    check_scan("after_tear", {SB, S7, S2, S3});

    // apagar mid-scan (aligned on a capture edge here)
    for (int i = 1; i <= 5; i++) step();
    apagar = 1'b1;
    for (int i = 6; i <= 12; i++) begin
      step();
      chk($sformatf("apagar e%0d an", i), {28'd0, anodos}, 32'b1111);
      chk($sformatf("apagar e%0d seg", i), {25'd0, segmentos}, {25'd0, (i <= 8) ? S2 : S7});
    end
    apagar = 1'b0;
    for (int i = 13; i <= 16; i++) begin
      step();
      chk($sformatf("resume e%0d an", i), {28'd0, anodos}, 32'b0111);
      chk($sformatf("resume e%0d seg", i), {25'd0, segmentos}, {25'd0, SB});
    end

    // Buzzer: single one-cycle pulse
    buzzer_in = 1'b1;
    chk("buz pre-edge", {31'd0, buzzer_out}, 32'd0);
    for (int i = 0; i < 15; i++) begin
      buzzer_in = (i == 0);
      step();
      chk($sformatf("buz single c%0d", i), {31'd0, buzzer_out}, {31'd0, (i < 10)});
    end
    // Retrigger 5 cycles later extends to 10 cycles after the second pulse
    for (int i = 0; i < 20; i++) begin
      buzzer_in = (i == 0) || (i == 5);
      step();
      chk($sformatf("buz retrig c%0d", i), {31'd0, buzzer_out}, {31'd0, (i < 15)});
    end
    // Held level: one pulse only
    for (int i = 0; i < 60; i++) begin
      buzzer_in = (i < 50);
      step();
      chk($sformatf("buz held c%0d", i), {31'd0, buzzer_out}, {31'd0, (i < 10)});
    end
    buzzer_in = 1'b0;

    // Reset mid-operation with index 2 and buzzer active
    sync_capture();
    for (int i = 1; i <= 8; i++) step();
    buzzer_in = 1'b1;
    step();
    buzzer_in = 1'b0;
    chk("pre-reset buz", {31'd0, buzzer_out}, 32'd1);
    chk("pre-reset an",  {28'd0, anodos},     32'b1011);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset an",  {28'd0, anodos},     32'b1111);
    chk("async reset seg", {25'd0, segmentos},  32'b1111111);
    chk("async reset buz", {31'd0, buzzer_out}, 32'd0);
    step(); step();
    reset = 1'b0;
    ncyc  = 0;
    step();
    chk("rerun e1 an",  {28'd0, anodos},     32'b1110);
    chk("rerun e1 buz", {31'd0, buzzer_out}, 32'd0);
    step();
    chk("rerun e2 seg", {25'd0, segmentos}, {25'd0, S3});
    step(); step(); step();
    chk("rerun e5 an",  {28'd0, anodos},    32'b1101);
    chk("rerun e5 seg", {25'd0, segmentos}, {25'd0, S2});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
